mem_access_unit: RTL
====================

# mem_access_unit

Parametrised memory-access stage for the RISC-V core, sitting between EX and WB. Executes all RV32I/RV64I load/store widths with byte enables, sign/zero extension and alignment checking. Talks to data memory over a req/ack handshake that may take several cycles, stalls upstream while a transfer is outstanding, and aborts on timeout. Non-memory results pass through with one cycle of latency.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64 only.
- REG_AW, 5: register address width.
- TIMEOUT, 16: maximum wait cycles for `dmem_ack_i` before abort; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_i  in  1  EX result present.
- ready_o  out  1  stage can accept; high only in IDLE.
- is_load_i / is_store_i  in  1  memory op class; both 0 means pass-through; both 1 is illegal.
- funct3_i  in  3  RISC-V load/store funct3.
- addr_i  in  XLEN  effective address.
- store_data_i  in  XLEN  rs2 value.
- alu_result_i  in  XLEN  pass-through writeback value.
- wb_en_i  in  1  writeback enable from decode.
- rd_addr_i  in  REG_AW  destination register.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_addr_o  out  XLEN  lane-aligned address.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_ack_i  in  1  transfer complete; rdata valid in the same cycle.
- dmem_rdata_i  in  XLEN  read data.
- valid_o  out  1  single-cycle result pulse to WB.
- wb_en_o  out  1  write rd.
- rd_addr_o  out  REG_AW  destination.
- wb_data_o  out  XLEN  writeback data.
- fault_o  out  1  exception pulse, coincident with valid_o.
- fault_code_o  out  2  01 misaligned, 10 timeout, 11 illegal op.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: accept on `valid_i`. For pass-through, go to DONE with `wb_data_o = alu_result_i`. For a legal, aligned memory op, latch op, address and data, then go to REQ. Misaligned or illegal ops go to DONE with a fault and issue no memory request.
- REQ: drive `dmem_req_o` and hold all `dmem_*` outputs stable until `dmem_ack_i`, then go to DONE. The wait counter increments each REQ cycle. When it reaches TIMEOUT without an ack, drop the request, go to DONE, and raise fault 10.
- DONE: pulse `valid_o` for one cycle, then return to IDLE.
- Any fault forces `wb_en_o=0`. Stores also force `wb_en_o=0`.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU only when XLEN=64.
  - Stores: 000 SB, 001 SH, 010 SW; 011 SD only when XLEN=64.
  - Every other value is illegal (fault 11).
- Alignment is natural: address offset modulo access size must be 0.
- Lane offset is `addr[log2(XLEN/8)-1:0]`.
- `dmem_addr_o` is the address with the offset bits cleared.
- `dmem_be_o` is the size mask shifted left by the offset.
- `dmem_wdata_o` is the low bytes of the store data replicated across all lanes.
- Load data: extract the selected lanes from `dmem_rdata_i` at ack, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to XLEN. Register the result into `wb_data_o`.

## Timing
- Reset values: state IDLE, counter 0. All outputs are 0 except `ready_o=1`.
- Pass-through and fault paths: accept in cycle N, `valid_o` in N+1.
- Memory path: accept in cycle N, `dmem_req_o` high from N+1.
  - An ack in cycle M gives `valid_o` in M+1.
  - Minimum memory-op latency is 2 cycles.
- `ready_o` is low from N+1 until the DONE cycle inclusive. A new accept is possible in the cycle after DONE.
- An ack received outside REQ is ignored.
- An ack arriving in the same cycle the counter hits TIMEOUT wins: the transfer completes and no fault is raised.
- `rst` during REQ: the request drops the next cycle, and any pending ack and result are discarded.
- `valid_i` while `ready_o=0` is ignored; upstream must hold its inputs.

## Structure
- Package `riscv_mem_pkg`: funct3 encodings, fault code constants, state enum, and a size-from-funct3 function.
- Sub-module `load_align`: combinational lane extract plus sign/zero extension, parametrised by XLEN.
- FSM, counter and store lane logic live in the top module.

## Test plan
- LW, XLEN=32, addr 0x104, rdata 0xDEADBEEF, ack one cycle after req:
  - `be=1111`, `dmem_addr_o=0x104`, `wb_data_o=0xDEADBEEF`.
  - `valid_o` 2 cycles after accept.
- LB at addr 0x103 with rdata 0x80112233 → `be=1000`, `wb_data_o=0xFFFFFF80`.
- LBU at the same address and rdata → `wb_data_o=0x00000080`.
- SH at addr 0x102 with store data 0x0000ABCD:
  - `be=1100`, `wdata=0xABCDABCD`, `we=1`, `wb_en_o=0`.
  - Ack delayed 5 cycles: `ready_o` stays low and all `dmem_*` outputs stay stable.
- LW at addr 0x102 → no `dmem_req_o`, `fault_code_o=01`, `valid_o` in N+1.
- No ack with TIMEOUT=4 → request held 4 cycles, then fault 10.
- Ack landing exactly on cycle 4 → normal completion, no fault.
- `rst` during REQ → `dmem_req_o` is 0 next cycle and no `valid_o` is produced.
- XLEN=64: LD at addr 0x8 returns all 64 bits; LWU of 0xFFFFFFFF gives 0x00000000FFFFFFFF. With XLEN=32, LD gives fault 11.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - load/store encodings, fault codes and FSM state for the memory stage.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_e;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_log2(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic op_legal(input logic is_load, input logic is_store,
                                    input logic [2:0] funct3, input logic xlen64);
    logic ok;
    ok = 1'b0;
    if (is_load && !is_store) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        F3_D, F3_WU:                    ok = xlen64;
        default:                        ok = 1'b0;
      endcase
    end else if (is_store && !is_load) begin
      case (funct3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        F3_D:             ok = xlen64;
        default:          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed lanes of read data and sign/zero extends to XLEN.
module load_align #(
  parameter  int XLEN = 32,
  localparam int OW   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [OW-1:0]   offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // funct3[2] marks the unsigned variants
  always_comb begin
    data_o = shifted;
    case (funct3_i[1:0])
      2'b00:   data_o = funct3_i[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   data_o = funct3_i[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   data_o = funct3_i[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: load/store lane steering, req/ack data memory port with timeout.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                is_load_i,
  input  logic                is_store_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     store_data_i,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic                wb_en_i,
  input  logic [REG_AW-1:0]   rd_addr_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_ack_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic                valid_o,
  output logic                wb_en_o,
  output logic [REG_AW-1:0]   rd_addr_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                fault_o,
  output logic [1:0]          fault_code_o
);

  localparam int BW = XLEN/8;
  localparam int OW = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [BW-1:0]       be_q, be_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [OW-1:0]       off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic                wen_q, wen_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [1:0]          code_q, code_d;

  logic [OW-1:0]       off_in;
  logic [1:0]          sz;
  logic [BW-1:0]       size_mask;
  logic [BW-1:0]       be_in;
  logic [OW-1:0]       amask;
  logic                misaligned;
  logic                legal;
  logic [XLEN-1:0]     wdata_in;
  logic [XLEN-1:0]     ld_data;

  assign off_in     = addr_i[OW-1:0];
  assign sz         = size_log2(funct3_i);
  assign amask      = OW'((8'd1 << sz) - 8'd1);
  assign misaligned = |(off_in & amask);
  assign legal      = op_legal(is_load_i, is_store_i, funct3_i, XLEN == 64);
  assign be_in      = size_mask << off_in;

  always_comb begin
    case (sz)
      2'd0:    size_mask = BW'(1);
      2'd1:    size_mask = BW'(3);
      2'd2:    size_mask = BW'(15);
      default: size_mask = BW'(255);
    endcase
  end

  // each lane i takes store byte (i mod access size), replicating the low bytes
  always_comb begin
    int lm;
    lm = (1 << sz) - 1;
    wdata_in = '0;
    for (int i = 0; i < BW; i++) begin
      wdata_in[8*i +: 8] = store_data_i[8*(i & lm) +: 8];
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dmem_rdata_i),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wen_d   = wen_q;
    rd_d    = rd_q;
    res_d   = res_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (valid_i) begin
          rd_d    = rd_addr_i;
          f3_d    = funct3_i;
          off_d   = off_in;
          be_d    = be_in;
          addr_d  = {addr_i[XLEN-1:OW], {OW{1'b0}}};
          wdata_d = wdata_in;
          we_d    = is_store_i;
          res_d   = '0;
          code_d  = FAULT_NONE;
          wen_d   = 1'b0;
          state_d = ST_DONE;
          if (!is_load_i && !is_store_i) begin
            res_d = alu_result_i;
            wen_d = wb_en_i;
          end else if (!legal) begin
            code_d = FAULT_ILLEGAL;
          end else if (misaligned) begin
            code_d = FAULT_MISALIGN;
          end else begin
            wen_d   = wb_en_i & is_load_i;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // an ack on the final permitted cycle still completes normally
        if (dmem_ack_i) begin
          res_d   = we_q ? '0 : ld_data;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = FAULT_TIMEOUT;
          wen_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      res_q   <= '0;
      code_q  <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      code_q  <= code_d;
    end
  end

  logic in_req, in_done;
  assign in_req  = (state_q == ST_REQ);
  assign in_done = (state_q == ST_DONE);

  assign ready_o      = (state_q == ST_IDLE);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & we_q;
  assign dmem_be_o    = in_req ? be_q : '0;
  assign dmem_addr_o  = in_req ? addr_q : '0;
  assign dmem_wdata_o = in_req ? wdata_q : '0;
  assign valid_o      = in_done;
  assign wb_en_o      = in_done & wen_q;
  assign rd_addr_o    = in_done ? rd_q : '0;
  assign wb_data_o    = in_done ? res_q : '0;
  assign fault_o      = in_done & (code_q != FAULT_NONE);
  assign fault_code_o = in_done ? code_q : FAULT_NONE;

endmodule
